// File: rtl/sram_responder.sv
// Clocked stand-in for an asynchronous SRAM's pins, used for loopback testing of the SRAM controller.
// It registers the pins, commits writes when WE/CE rise, and drives read data after a programmable latency.
module sram_responder #(
  parameter int ADDR_BITS     = 20,
  parameter int DATA_BITS     = 16,
  parameter int MEM_ADDR_BITS = 10,
  parameter int READ_LATENCY  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addr_bus,
  inout  wire  [DATA_BITS-1:0] data_bus,
  input  logic                 ce_n,
  input  logic                 we_n,
  input  logic                 oe_n,
  output logic [15:0]          write_count,
  output logic [15:0]          read_count,
  output logic                 contention,
  output logic                 addr_err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_DRIVE} state_t;

  // READ_WAIT lasts READ_LATENCY-1 cycles, so the drive starts READ_LATENCY edges after the sampling edge.
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 2);

  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 ce_n_q, we_n_q, oe_n_q;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [2:0]           lat_cnt_q, lat_cnt_d;
  logic                 drive_q, drive_d;
  logic [15:0]          wcount_q, wcount_d, rcount_q, rcount_d;
  logic                 contention_q, contention_d, addr_err_q, addr_err_d;
  logic                 mem_we;

  logic [DATA_BITS-1:0] mem [2**MEM_ADDR_BITS];

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_data_d    = wr_data_q;
    lat_cnt_d    = lat_cnt_q;
    drive_d      = drive_q;
    wcount_d     = wcount_q;
    rcount_d     = rcount_q;
    contention_d = contention_q;
    addr_err_d   = addr_err_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        drive_d = 1'b0;
        if (!ce_n_q && !we_n_q) begin
          state_d   = WRITE;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
        end else if (!ce_n_q && !oe_n_q) begin
          state_d   = READ_WAIT;
          rd_addr_d = addr_q;
          lat_cnt_d = LAT_LOAD;
        end
      end
      WRITE: begin
        wr_data_d = data_q;
        if (ce_n_q || we_n_q) begin
          // Commit the word latched while the phase was still active.
          mem_we   = 1'b1;
          wcount_d = (wcount_q == 16'hFFFF) ? wcount_q : wcount_q + 16'd1;
          state_d  = IDLE;
        end else if (addr_q != wr_addr_q) begin
          addr_err_d = 1'b1;
        end
      end
      READ_WAIT: begin
        if (!ce_n_q && !we_n_q) begin
          state_d   = WRITE;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
        end else if (ce_n_q || oe_n_q) begin
          state_d = IDLE;
        end else if (lat_cnt_q == 3'd0) begin
          state_d  = READ_DRIVE;
          drive_d  = 1'b1;
          rcount_d = (rcount_q == 16'hFFFF) ? rcount_q : rcount_q + 16'd1;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      READ_DRIVE: begin
        if (!we_n_q) begin
          // Controller wrote over our drive: the write lands on the address being read.
          contention_d = 1'b1;
          drive_d      = 1'b0;
          if (!ce_n_q) begin
            state_d   = WRITE;
            wr_addr_d = rd_addr_q;
            wr_data_d = data_q;
          end else begin
            state_d = IDLE;
          end
        end else if (ce_n_q || oe_n_q) begin
          drive_d = 1'b0;
          state_d = IDLE;
        end else if (addr_q != rd_addr_q) begin
          drive_d   = 1'b0;
          rd_addr_d = addr_q;
          lat_cnt_d = LAT_LOAD;
          state_d   = READ_WAIT;
        end
      end
      default: begin
        drive_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      data_q       <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_data_q    <= '0;
      lat_cnt_q    <= '0;
      drive_q      <= 1'b0;
      wcount_q     <= '0;
      rcount_q     <= '0;
      contention_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      addr_q       <= addr_bus;
      data_q       <= data_bus;
      ce_n_q       <= ce_n;
      we_n_q       <= we_n;
      oe_n_q       <= oe_n;
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_data_q    <= wr_data_d;
      lat_cnt_q    <= lat_cnt_d;
      drive_q      <= drive_d;
      wcount_q     <= wcount_d;
      rcount_q     <= rcount_d;
      contention_q <= contention_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q[MEM_ADDR_BITS-1:0]] <= wr_data_q;
    end
  end

  assign data_bus    = drive_q ? mem[rd_addr_q[MEM_ADDR_BITS-1:0]] : {DATA_BITS{1'bz}};
  assign write_count = wcount_q;
  assign read_count  = rcount_q;
  assign contention  = contention_q;
  assign addr_err    = addr_err_q;

endmodule
